// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch address, runs the variable-latency
// imem handshake, buffers one instruction plus one skid entry while the
// pipeline is frozen, and redirects on EXE branches.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | after reset, no request; always moves to FETCH on the next edge
// FETCH | request outstanding at req_addr
// STALL | buffer and skid both full, no request until the buffer drains
// DRAIN | request for a killed fetch still outstanding at drain_addr
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {IDLE, FETCH, STALL, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] req_addr, req_addr_nx;
  logic [31:0] drain_addr, drain_addr_nx;
  logic [31:0] skid_instr, skid_instr_nx;
  logic [31:0] skid_pc, skid_pc_nx;
  logic [31:0] instr_nx, pc_nx;
  logic        valid_nx;
  logic        consume;
  logic [31:0] fetch_next;

  assign consume    = valid_out & ~freeze;
  assign fetch_next = req_addr + 32'd4;

  // Request outputs decode registered state only; no path from imem_ack.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drain_addr : req_addr;

  // Next-state and datapath decisions; a branch overrides everything else.
  always_comb begin
    state_nx      = state;
    req_addr_nx   = req_addr;
    drain_addr_nx = drain_addr;
    skid_instr_nx = skid_instr;
    skid_pc_nx    = skid_pc;
    instr_nx      = instr_out;
    pc_nx         = pc_out;
    valid_nx      = valid_out & ~consume;

    case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        if (imem_ack) begin
          req_addr_nx = fetch_next;
          if (!valid_out || !freeze) begin
            instr_nx = imem_rdata;
            pc_nx    = fetch_next;
            valid_nx = 1'b1;
          end else begin
            // Buffer is held by a frozen pipeline: park the word in the skid.
            skid_instr_nx = imem_rdata;
            skid_pc_nx    = fetch_next;
            state_nx      = STALL;
          end
        end
      end
      STALL: begin
        if (!freeze) begin
          instr_nx = skid_instr;
          pc_nx    = skid_pc;
          valid_nx = 1'b1;
          state_nx = FETCH;
        end
      end
      DRAIN: begin
        if (imem_ack) state_nx = FETCH;
      end
    endcase

    if (branch_taken) begin
      valid_nx      = 1'b0;
      req_addr_nx   = branch_addr;
      skid_instr_nx = '0;
      skid_pc_nx    = '0;
      instr_nx      = instr_out;
      pc_nx         = pc_out;
      drain_addr_nx = drain_addr;
      case (state)
        FETCH: begin
          // A pending request cannot be aborted; remember it so its data is dropped.
          if (!imem_ack) begin
            state_nx      = DRAIN;
            drain_addr_nx = req_addr;
          end else begin
            state_nx = FETCH;
          end
        end
        DRAIN:   state_nx = DRAIN;
        default: state_nx = FETCH;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_addr   <= RESET_PC;
      drain_addr <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      instr_out  <= '0;
      pc_out     <= '0;
      valid_out  <= 1'b0;
    end else begin
      state      <= state_nx;
      req_addr   <= req_addr_nx;
      drain_addr <= drain_addr_nx;
      skid_instr <= skid_instr_nx;
      skid_pc    <= skid_pc_nx;
      instr_out  <= instr_nx;
      pc_out     <= pc_nx;
      valid_out  <= valid_nx;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int wcnt = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .pc_out(pc_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: held instructions as a queue (buffer + skid, at most 2),
  // a "killed request pending" flag, and the next address to fetch.
  logic        m_idle = 1'b1;
  logic        m_kill = 1'b0;
  logic [31:0] m_next = 32'h0;
  logic [31:0] m_drain = 32'h0;
  logic [31:0] q_i[$];
  logic [31:0] q_p[$];

  function automatic logic model_req();
    return !m_idle && (m_kill || q_i.size() < 2);
  endfunction

  initial forever begin
    logic req;
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_idle = 1'b1; m_kill = 1'b0; m_next = 32'h0; m_drain = 32'h0;
      q_i.delete(); q_p.delete();
    end else begin
      req = model_req();
      if (branch_taken) begin
        if (req && !m_kill && !imem_ack) begin
          m_kill  = 1'b1;
          m_drain = m_next;
        end
        q_i.delete(); q_p.delete();
        m_next = branch_addr;
        m_idle = 1'b0;
      end else if (m_idle) begin
        m_idle = 1'b0;
      end else begin
        if (q_i.size() > 0 && !freeze) begin
          void'(q_i.pop_front());
          void'(q_p.pop_front());
        end
        if (req && imem_ack) begin
          if (m_kill) m_kill = 1'b0;
          else begin
            q_i.push_back(imem_rdata);
            q_p.push_back(m_next + 32'd4);
            m_next = m_next + 32'd4;
          end
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  initial forever begin
    logic req;
    @(negedge clk);
    req = model_req();
    chk("imem_req", {31'b0, imem_req}, {31'b0, req});
    if (req) chk("imem_addr", imem_addr, m_kill ? m_drain : m_next);
    chk("valid_out", {31'b0, valid_out}, {31'b0, q_i.size() > 0});
    if (q_i.size() > 0) begin
      chk("instr_out", instr_out, q_i[0]);
      chk("pc_out", pc_out, q_p[0]);
      chk("pc_vs_instr", pc_out, {instr_out[29:0], 2'b00} + 32'd4);
    end
  end

  // Memory returns the word index of the address.
  task automatic drive_mem();
    if (rst && imem_req) begin
      if (wcnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = {2'b00, imem_addr[31:2]};
        wcnt       = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end
  endtask

  task automatic cyc(input logic f, input logic b, input logic [31:0] ba);
    @(posedge clk);
    #1;
    drive_mem();
    freeze       = f;
    branch_taken = b;
    branch_addr  = ba;
  endtask

  task automatic do_reset(input int l);
    @(posedge clk);
    #1;
    rst = 1'b0; imem_ack = 1'b0; freeze = 1'b0; branch_taken = 1'b0; wcnt = 0; lat = l;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] s;
    logic [31:0] tmp;
    logic [31:0] ba;
    int n;

    // Reset values, then steady zero-wait run.
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    lat = 0;
    cyc(0, 0, 0);
    chk("t1_req", {31'b0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_valid0", {31'b0, valid_out}, 32'd0);
    cyc(0, 0, 0);
    chk("t1_valid1", {31'b0, valid_out}, 32'd1);
    chk("t1_instr0", instr_out, 32'd0);
    chk("t1_pc0", pc_out, 32'h4);
    chk("t1_addr1", imem_addr, 32'h4);
    cyc(0, 0, 0);
    chk("t1_instr1", instr_out, 32'd1);
    chk("t1_pc1", pc_out, 32'h8);
    cyc(0, 0, 0);

    // Freeze for three cycles with the skid filling.
    cyc(1, 0, 0);
    s = instr_out;
    cyc(1, 0, 0);
    chk("t2_stall_req", {31'b0, imem_req}, 32'd0);
    chk("t2_stable0", instr_out, s);
    cyc(1, 0, 0);
    chk("t2_stable1", instr_out, s);
    cyc(0, 0, 0);
    chk("t2_stable2", instr_out, s);
    chk("t2_stall_req2", {31'b0, imem_req}, 32'd0);
    cyc(0, 0, 0);
    chk("t2_skid_out", instr_out, s + 32'd1);
    chk("t2_resume_addr", imem_addr, (s + 32'd2) << 2);
    cyc(0, 0, 0);
    chk("t2_next", instr_out, s + 32'd2);

    // Branch while the request for 0x8 waits on a 2-cycle memory.
    do_reset(2);
    n = 0;
    do begin cyc(0, 0, 0); n++; end
    while (!(imem_req && imem_addr == 32'h8 && !imem_ack) && n < 40);
    chk("t3_reach_8", {31'b0, imem_req && imem_addr == 32'h8}, 32'd1);
    branch_taken = 1'b1; branch_addr = 32'h100;
    cyc(0, 0, 0);
    chk("t3_hold_8", imem_addr, 32'h8);
    chk("t3_valid0", {31'b0, valid_out}, 32'd0);
    n = 0;
    while (imem_addr == 32'h8 && n < 20) begin cyc(0, 0, 0); n++; end
    chk("t3_target", imem_addr, 32'h100);
    chk("t3_valid0b", {31'b0, valid_out}, 32'd0);
    n = 0;
    while (!valid_out && n < 20) begin cyc(0, 0, 0); n++; end
    chk("t3_instr", instr_out, 32'h40);
    chk("t3_pc", pc_out, 32'h104);

    // Branch coincident with an ack.
    do_reset(0);
    repeat (4) cyc(0, 0, 0);
    chk("t4_ack", {31'b0, imem_ack}, 32'd1);
    branch_taken = 1'b1; branch_addr = 32'h200;
    cyc(0, 0, 0);
    chk("t4_valid0", {31'b0, valid_out}, 32'd0);
    chk("t4_addr", imem_addr, 32'h200);
    cyc(0, 0, 0);
    chk("t4_instr", instr_out, 32'h80);
    chk("t4_pc", pc_out, 32'h204);

    // Branch while stalled with the skid full.
    do_reset(0);
    repeat (3) cyc(0, 0, 0);
    freeze = 1'b1;
    cyc(1, 0, 0);
    chk("t5_stall", {31'b0, imem_req}, 32'd0);
    chk("t5_valid1", {31'b0, valid_out}, 32'd1);
    branch_taken = 1'b1; branch_addr = 32'h300;
    cyc(1, 0, 0);
    chk("t5_valid0", {31'b0, valid_out}, 32'd0);
    chk("t5_addr", imem_addr, 32'h300);
    cyc(0, 0, 0);
    chk("t5_instr", instr_out, 32'hC0);
    chk("t5_pc", pc_out, 32'h304);

    // Asynchronous reset while draining.
    do_reset(3);
    n = 0;
    do begin cyc(0, 0, 0); n++; end
    while (!(imem_req && imem_addr == 32'h4 && !imem_ack) && n < 40);
    branch_taken = 1'b1; branch_addr = 32'h400;
    cyc(0, 0, 0);
    chk("t6_drain_addr", imem_addr, 32'h4);
    #3 rst = 1'b0; imem_ack = 1'b0; wcnt = 0;
    #2;
    chk("t6_valid", {31'b0, valid_out}, 32'd0);
    chk("t6_req", {31'b0, imem_req}, 32'd0);
    chk("t6_pc", pc_out, 32'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    cyc(0, 0, 0);
    chk("t6_restart_req", {31'b0, imem_req}, 32'd1);
    chk("t6_restart_addr", imem_addr, 32'h0);
    repeat (6) cyc(0, 0, 0);

    // Randomized traffic.
    do_reset(0);
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) lat = $urandom_range(0, 3);
      tmp = $urandom;
      ba = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : {tmp[31:2], 2'b00};
      cyc($urandom_range(0, 99) < 30, $urandom_range(0, 19) == 0, ba);
    end
    repeat (8) cyc(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
